// File: rtl/pipeline_controller_if.sv
// Hazard/wait inputs and per-latch stall/flush controls between the pipeline
// stages and the central pipeline controller.
interface pipeline_controller_if;
   logic        id_load_use;
   logic        ex_div_start;
   logic        mem_request;
   logic        mem_ready;
   logic        mem_exception;
   logic [4:0]  stall;
   logic [4:0]  flush;
   logic        pc_redirect;
   logic        ex_div_done;
   logic [31:0] stall_cycles;

   modport master (
      output id_load_use, ex_div_start, mem_request, mem_ready, mem_exception,
      input  stall, flush, pc_redirect, ex_div_done, stall_cycles
   );

   modport slave (
      input  id_load_use, ex_div_start, mem_request, mem_ready, mem_exception,
      output stall, flush, pc_redirect, ex_div_done, stall_cycles
   );
endinterface

// File: rtl/pipeline_controller.sv
// Central stall/flush sequencer for the 5-stage pipeline: prioritises
// exception, memory wait, divide busy and load-use hazards, sequences
// multi-cycle divides and counts stalled cycles.
//
// state | meaning
// RUN   | normal flow; a divide may start this cycle
// DIV   | divide occupying EX; div_count counts remaining busy cycles
module pipeline_controller #(
   parameter int unsigned DIV_CYCLES = 32
) (
   input logic                  clock,
   input logic                  reset,
   pipeline_controller_if.slave bus
);

   typedef enum logic {RUN, DIV} state_t;

   // ex_div_start counts as the first busy cycle, so the counter covers the rest
   localparam logic [7:0] DIV_LOAD = 8'(DIV_CYCLES - 2);

   state_t      state;
   state_t      state_next;
   logic [7:0]  div_count;
   logic [7:0]  div_count_next;
   logic [31:0] stall_cycles;

   logic [4:0]  stall_c;
   logic [4:0]  flush_c;
   logic        redirect_c;
   logic        done_c;
   logic        mem_wait;
   logic        div_busy;

   // Priority decode of hazard controls and divide sequencing
   always_comb begin
      stall_c        = 5'b00000;
      flush_c        = 5'b00000;
      redirect_c     = 1'b0;
      done_c         = 1'b0;
      state_next     = state;
      div_count_next = div_count;

      mem_wait = bus.mem_request & ~bus.mem_ready;
      div_busy = ((state == RUN) & bus.ex_div_start) |
                 ((state == DIV) & (div_count != 8'd0));

      if (bus.mem_exception) begin
         flush_c    = 5'b01110;
         redirect_c = 1'b1;
      end else if (mem_wait) begin
         stall_c = 5'b01111;
         flush_c = 5'b10000;
      end else if (div_busy) begin
         stall_c = 5'b00111;
         flush_c = 5'b01000;
      end else if (bus.id_load_use) begin
         stall_c = 5'b00011;
         flush_c = 5'b00100;
      end

      case (state)
         RUN: begin
            if (bus.ex_div_start && !bus.mem_exception) begin
               state_next     = DIV;
               div_count_next = DIV_LOAD;
            end
         end
         DIV: begin
            if (bus.mem_exception) begin
               state_next     = RUN;
               div_count_next = 8'd0;
            end else if (div_count != 8'd0) begin
               div_count_next = div_count - 8'd1;
            end else if (!mem_wait) begin
               // result leaves EX only once MEM is no longer holding the pipe
               done_c     = 1'b1;
               state_next = RUN;
            end
         end
         default: begin
            state_next     = RUN;
            div_count_next = 8'd0;
         end
      endcase

      if (reset) begin
         stall_c    = 5'b00000;
         flush_c    = 5'b00000;
         redirect_c = 1'b0;
         done_c     = 1'b0;
      end
   end

   // State, divide counter and stalled-cycle counter
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state        <= RUN;
         div_count    <= 8'd0;
         stall_cycles <= 32'd0;
      end else begin
         state     <= state_next;
         div_count <= div_count_next;
         if (stall_c[0])
            stall_cycles <= stall_cycles + 32'd1;
      end
   end

   assign bus.stall        = stall_c;
   assign bus.flush        = flush_c;
   assign bus.pc_redirect  = redirect_c;
   assign bus.ex_div_done  = done_c;
   assign bus.stall_cycles = stall_cycles;

endmodule
